// File: rtl/ps2_ascii_decoder_pkg.sv
// Shared definitions for the PS/2 scan-code-set-2 to ASCII decoder:
// prefix-tracking state encoding, scan-code constants, ASCII control
// codes and a helper that recognises keyboard controller responses.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BRK    = 2'd1,
    S_EXT    = 2'd2,
    S_EXTBRK = 2'd3
  } ps2_state_e;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  localparam logic [6:0] ASCII_CR  = 7'd13;
  localparam logic [6:0] ASCII_BS  = 7'd8;

  // Bytes the keyboard sends as controller responses (BAT, ACK, echo,
  // resend, errors); they never denote a key.
  function automatic logic is_ctrl_resp(input logic [7:0] code);
    logic resp;
    case (code)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: resp = 1'b1;
      default:                                  resp = 1'b0;
    endcase
    return resp;
  endfunction

endpackage

// File: rtl/ps2_ascii_decoder_if.sv
// Byte/character bus between the PS/2 receiver, the decoder and the text
// editor stage.
//   master : the receiver side (drives ps2_byte/ps2_valid/ps2_err)
//   slave  : the decoder (drives asciiout/asciiready/shift_o/caps_o)
interface ps2_ascii_decoder_if;
  logic [7:0] ps2_byte;
  logic       ps2_valid;
  logic       ps2_err;
  logic [6:0] asciiout;
  logic       asciiready;
  logic       shift_o;
  logic       caps_o;

  modport master (
    output ps2_byte, ps2_valid, ps2_err,
    input  asciiout, asciiready, shift_o, caps_o
  );

  modport slave (
    input  ps2_byte, ps2_valid, ps2_err,
    output asciiout, asciiready, shift_o, caps_o
  );
endinterface

// File: rtl/ps2_ascii_decoder_lut.sv
// Combinational scan-code-set-2 make-code to ASCII lookup.
//   code_i  : scan code
//   shift_i : either shift key held
//   caps_i  : caps-lock state
//   ascii_o : 7-bit ASCII, 0 when the code has no printable mapping
// Letters honour shift XOR caps; digits/punctuation honour shift only.
module ps2_scancode_lut
  import ps2_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic       shift_i,
  input  logic       caps_i,
  output logic [6:0] ascii_o
);

  logic [6:0] lo_s;
  logic [6:0] hi_s;
  logic       letter_s;

  // Table lookup: unshifted glyph, shifted glyph and letter flag.
  always_comb begin
    lo_s     = 7'h00;
    hi_s     = 7'h00;
    letter_s = 1'b0;
    case (code_i)
      8'h1C: begin lo_s = 7'h61; letter_s = 1'b1; end
      8'h32: begin lo_s = 7'h62; letter_s = 1'b1; end
      8'h21: begin lo_s = 7'h63; letter_s = 1'b1; end
      8'h23: begin lo_s = 7'h64; letter_s = 1'b1; end
      8'h24: begin lo_s = 7'h65; letter_s = 1'b1; end
      8'h2B: begin lo_s = 7'h66; letter_s = 1'b1; end
      8'h34: begin lo_s = 7'h67; letter_s = 1'b1; end
      8'h33: begin lo_s = 7'h68; letter_s = 1'b1; end
      8'h43: begin lo_s = 7'h69; letter_s = 1'b1; end
      8'h3B: begin lo_s = 7'h6A; letter_s = 1'b1; end
      8'h42: begin lo_s = 7'h6B; letter_s = 1'b1; end
      8'h4B: begin lo_s = 7'h6C; letter_s = 1'b1; end
      8'h3A: begin lo_s = 7'h6D; letter_s = 1'b1; end
      8'h31: begin lo_s = 7'h6E; letter_s = 1'b1; end
      8'h44: begin lo_s = 7'h6F; letter_s = 1'b1; end
      8'h4D: begin lo_s = 7'h70; letter_s = 1'b1; end
      8'h15: begin lo_s = 7'h71; letter_s = 1'b1; end
      8'h2D: begin lo_s = 7'h72; letter_s = 1'b1; end
      8'h1B: begin lo_s = 7'h73; letter_s = 1'b1; end
      8'h2C: begin lo_s = 7'h74; letter_s = 1'b1; end
      8'h3C: begin lo_s = 7'h75; letter_s = 1'b1; end
      8'h2A: begin lo_s = 7'h76; letter_s = 1'b1; end
      8'h1D: begin lo_s = 7'h77; letter_s = 1'b1; end
      8'h22: begin lo_s = 7'h78; letter_s = 1'b1; end
      8'h35: begin lo_s = 7'h79; letter_s = 1'b1; end
      8'h1A: begin lo_s = 7'h7A; letter_s = 1'b1; end
      8'h16: begin lo_s = 7'h31; hi_s = 7'h21; end
      8'h1E: begin lo_s = 7'h32; hi_s = 7'h40; end
      8'h26: begin lo_s = 7'h33; hi_s = 7'h23; end
      8'h25: begin lo_s = 7'h34; hi_s = 7'h24; end
      8'h2E: begin lo_s = 7'h35; hi_s = 7'h25; end
      8'h36: begin lo_s = 7'h36; hi_s = 7'h5E; end
      8'h3D: begin lo_s = 7'h37; hi_s = 7'h26; end
      8'h3E: begin lo_s = 7'h38; hi_s = 7'h2A; end
      8'h46: begin lo_s = 7'h39; hi_s = 7'h28; end
      8'h45: begin lo_s = 7'h30; hi_s = 7'h29; end
      8'h0E: begin lo_s = 7'h60; hi_s = 7'h7E; end
      8'h4E: begin lo_s = 7'h2D; hi_s = 7'h5F; end
      8'h55: begin lo_s = 7'h3D; hi_s = 7'h2B; end
      8'h54: begin lo_s = 7'h5B; hi_s = 7'h7B; end
      8'h5B: begin lo_s = 7'h5D; hi_s = 7'h7D; end
      8'h5D: begin lo_s = 7'h5C; hi_s = 7'h7C; end
      8'h4C: begin lo_s = 7'h3B; hi_s = 7'h3A; end
      8'h52: begin lo_s = 7'h27; hi_s = 7'h22; end
      8'h41: begin lo_s = 7'h2C; hi_s = 7'h3C; end
      8'h49: begin lo_s = 7'h2E; hi_s = 7'h3E; end
      8'h4A: begin lo_s = 7'h2F; hi_s = 7'h3F; end
      8'h29: begin lo_s = 7'h20;     hi_s = 7'h20;     end
      8'h5A: begin lo_s = ASCII_CR;  hi_s = ASCII_CR;  end
      8'h66: begin lo_s = ASCII_BS;  hi_s = ASCII_BS;  end
      8'h0D: begin lo_s = 7'h09;     hi_s = 7'h09;     end
      default: begin lo_s = 7'h00; hi_s = 7'h00; letter_s = 1'b0; end
    endcase
  end

  // Case selection: letters flip to uppercase on shift XOR caps.
  always_comb begin
    if (letter_s) begin
      if (shift_i ^ caps_i) begin
        ascii_o = lo_s - 7'd32;
      end else begin
        ascii_o = lo_s;
      end
    end else if (shift_i) begin
      ascii_o = hi_s;
    end else begin
      ascii_o = lo_s;
    end
  end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 scan-code-set-2 byte stream to 7-bit ASCII decoder.
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : slave side of ps2_ascii_decoder_if
//            in : ps2_byte, ps2_valid, ps2_err
//            out: asciiout (held), asciiready (1-cycle strobe),
//                 shift_o, caps_o
// Tracks break (F0) and extended (E0) prefixes, both shifts and caps lock.
// A prefix left dangling for TIMEOUT_CYCLES idle cycles is dropped.
module ps2_ascii_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic             clk,
  input  logic             resetn,
  ps2_ascii_decoder_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    state_q;
  logic          lshift_q;
  logic          rshift_q;
  logic          shift_q;
  logic          caps_q;
  logic          caps_held_q;
  logic [TW-1:0] timer_q;
  logic [6:0]    asciiout_q;
  logic          asciiready_q;
  logic [6:0]    lut_s;

  ps2_scancode_lut u_lut (
    .code_i  (bus.ps2_byte),
    .shift_i (shift_q),
    .caps_i  (caps_q),
    .ascii_o (lut_s)
  );

  // Prefix FSM, modifier state, resync timer and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      shift_q      <= 1'b0;
      caps_q       <= 1'b0;
      caps_held_q  <= 1'b0;
      timer_q      <= '0;
      asciiout_q   <= 7'd0;
      asciiready_q <= 1'b0;
    end else begin
      asciiready_q <= 1'b0;
      if (bus.ps2_err) begin
        // Corrupt byte: drop any pending prefix, keep modifiers.
        state_q <= S_IDLE;
        timer_q <= '0;
      end else if (bus.ps2_valid) begin
        timer_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (bus.ps2_byte == SC_BREAK) begin
              state_q <= S_BRK;
            end else if (bus.ps2_byte == SC_EXT) begin
              state_q <= S_EXT;
            end else begin
              state_q <= S_IDLE;
              if (bus.ps2_byte == SC_LSHIFT) begin
                lshift_q <= 1'b1;
                shift_q  <= 1'b1;
              end else if (bus.ps2_byte == SC_RSHIFT) begin
                rshift_q <= 1'b1;
                shift_q  <= 1'b1;
              end else if (bus.ps2_byte == SC_CAPS) begin
                // Toggle once per physical press; typematic repeats are held off.
                if (!caps_held_q) begin
                  caps_q      <= ~caps_q;
                  caps_held_q <= 1'b1;
                end
              end else if (is_ctrl_resp(bus.ps2_byte)) begin
                asciiready_q <= 1'b0;
              end else if (lut_s != 7'd0) begin
                asciiout_q   <= lut_s;
                asciiready_q <= 1'b1;
              end else begin
                asciiready_q <= 1'b0;
              end
            end
          end
          S_BRK: begin
            state_q <= S_IDLE;
            if (bus.ps2_byte == SC_LSHIFT) begin
              lshift_q <= 1'b0;
              shift_q  <= rshift_q;
            end else if (bus.ps2_byte == SC_RSHIFT) begin
              rshift_q <= 1'b0;
              shift_q  <= lshift_q;
            end else if (bus.ps2_byte == SC_CAPS) begin
              caps_held_q <= 1'b0;
            end else begin
              caps_held_q <= caps_held_q;
            end
          end
          S_EXT: begin
            if (bus.ps2_byte == SC_BREAK) begin
              state_q <= S_EXTBRK;
            end else begin
              state_q <= S_IDLE;
              // Keypad Enter; fake shifts (E0 12) and the rest are ignored.
              if (bus.ps2_byte == SC_ENTER) begin
                asciiout_q   <= ASCII_CR;
                asciiready_q <= 1'b1;
              end
            end
          end
          S_EXTBRK: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end else if (state_q != S_IDLE) begin
        // Waiting for the byte after a prefix: give up after the timeout.
        if (timer_q >= T_LAST) begin
          state_q <= S_IDLE;
          timer_q <= '0;
        end else begin
          timer_q <= timer_q + TW'(1);
        end
      end else begin
        timer_q <= '0;
      end
    end
  end

  assign bus.asciiout   = asciiout_q;
  assign bus.asciiready = asciiready_q;
  assign bus.shift_o    = shift_q;
  assign bus.caps_o     = caps_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder with hand-computed ASCII results.
module tb_ps2_ascii_decoder;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  logic rdy_seen;

  ps2_ascii_decoder_if bus_if ();

  ps2_ascii_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle and sample the strobe half a cycle after the edge.
  task automatic tick();
    @(negedge clk);
    rdy_seen = bus_if.asciiready;
    if (bus_if.asciiready === 1'b1) pulses++;
  endtask

  task automatic send(input logic [7:0] b, input logic v, input logic e);
    bus_if.ps2_byte  = b;
    bus_if.ps2_valid = v;
    bus_if.ps2_err   = e;
    tick();
    bus_if.ps2_byte  = 8'h00;
    bus_if.ps2_valid = 1'b0;
    bus_if.ps2_err   = 1'b0;
  endtask

  // Send a byte; exp is the character expected one cycle later, -1 for none.
  task automatic key(input string tag, input logic [7:0] b, input int exp);
    send(b, 1'b1, 1'b0);
    check_eq(tag, (rdy_seen === 1'b1) ? int'(bus_if.asciiout) : -1, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int p0;
    bus_if.ps2_byte  = 8'h00;
    bus_if.ps2_valid = 1'b0;
    bus_if.ps2_err   = 1'b0;
    resetn = 1'b0;
    idle(3);
    check_eq("rst_ascii", int'(bus_if.asciiout), 0);
    check_eq("rst_ready", int'(bus_if.asciiready), 0);
    check_eq("rst_shift", int'(bus_if.shift_o), 0);
    check_eq("rst_caps", int'(bus_if.caps_o), 0);
    resetn = 1'b1;
    idle(2);

    // Plain make/break, strobe width.
    p0 = pulses;
    key("a_make", 8'h1C, 97);
    idle(1);
    check_eq("a_width", pulses - p0, 1);
    key("a_f0", 8'hF0, -1);
    key("a_brk", 8'h1C, -1);
    check_eq("a_pulses", pulses - p0, 1);

    // Shift.
    key("sh_make", 8'h12, -1);
    check_eq("sh_on", int'(bus_if.shift_o), 1);
    key("sh_A", 8'h1C, 65);
    key("sh_f0a", 8'hF0, -1);
    key("sh_brka", 8'h1C, -1);
    check_eq("sh_still", int'(bus_if.shift_o), 1);
    key("sh_f0", 8'hF0, -1);
    key("sh_brk", 8'h12, -1);
    check_eq("sh_off", int'(bus_if.shift_o), 0);
    key("sh_a", 8'h1C, 97);

    // Caps lock with typematic repeat, shift XOR caps.
    key("cp_make", 8'h58, -1);
    check_eq("cp_on", int'(bus_if.caps_o), 1);
    key("cp_rep", 8'h58, -1);
    check_eq("cp_rep_on", int'(bus_if.caps_o), 1);
    key("cp_f0", 8'hF0, -1);
    key("cp_brk", 8'h58, -1);
    check_eq("cp_held", int'(bus_if.caps_o), 1);
    key("cp_A", 8'h1C, 65);
    key("cp_1", 8'h16, 49);
    key("cp_sh", 8'h12, -1);
    key("cp_xor", 8'h1C, 97);
    key("cp_shf0", 8'hF0, -1);
    key("cp_shbrk", 8'h12, -1);
    key("cp_make2", 8'h58, -1);
    check_eq("cp_off", int'(bus_if.caps_o), 0);
    key("cp_f02", 8'hF0, -1);
    key("cp_brk2", 8'h58, -1);

    // Fixed codes and extended prefix.
    key("enter", 8'h5A, 13);
    key("bksp", 8'h66, 8);
    key("space", 8'h29, 32);
    key("tab", 8'h0D, 9);
    key("e0", 8'hE0, -1);
    key("kp_enter", 8'h5A, 13);
    key("e0b", 8'hE0, -1);
    key("e0b_f0", 8'hF0, -1);
    key("e0b_5a", 8'h5A, -1);
    key("e0s", 8'hE0, -1);
    key("fake_sh", 8'h12, -1);
    check_eq("fake_sh_off", int'(bus_if.shift_o), 0);
    key("e0_idle", 8'h1C, 97);
    key("resp_aa", 8'hAA, -1);
    key("unmapped", 8'h76, -1);

    // Timeout: short gap keeps the prefix, full gap drops it.
    key("to_f0a", 8'hF0, -1);
    idle(4);
    key("to_keep", 8'h1C, -1);
    key("to_f0b", 8'hF0, -1);
    idle(TO);
    key("to_drop", 8'h1C, 97);

    // Reset mid-sequence drops the prefix.
    key("rs_f0", 8'hF0, -1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    key("rs_a", 8'h1C, 97);

    // Error strobe.
    send(8'h16, 1'b1, 1'b1);
    check_eq("err_noemit", (rdy_seen === 1'b1) ? 1 : 0, 0);
    key("rep1", 8'h16, 49);
    key("rep2", 8'h16, 49);
    key("rep3", 8'h16, 49);
    key("bang_sh", 8'h12, -1);
    key("bang", 8'h16, 33);
    key("bang_f0", 8'hF0, -1);
    key("bang_brk", 8'h12, -1);
    key("ec_make", 8'h58, -1);
    key("ec_f0", 8'hF0, -1);
    key("ec_brk", 8'h58, -1);
    key("ef_f0", 8'hF0, -1);
    send(8'h1C, 1'b0, 1'b1);
    check_eq("err_caps_kept", int'(bus_if.caps_o), 1);
    key("err_resync", 8'h1C, 65);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
